// File: rtl/spi_rx_if.sv
// Link bundle between the lidar TX serialiser and the spi_rx receiver.
// The master drives sync/din; the slave (receiver) returns the assembled word and status.
interface spi_rx_if #(
  parameter int unsigned WIDTH = 24
) ();
  logic             sync;
  logic             din;
  logic [WIDTH-1:0] data_out;
  logic             word_valid;
  logic             frame_err;
  logic [7:0]       frame_count;
  logic             busy;

  modport master (
    output sync,
    output din,
    input  data_out,
    input  word_valid,
    input  frame_err,
    input  frame_count,
    input  busy
  );

  modport slave (
    input  sync,
    input  din,
    output data_out,
    output word_valid,
    output frame_err,
    output frame_count,
    output busy
  );
endinterface

// File: rtl/spi_rx.sv
// Frame-synchronised serial-to-parallel receiver: MSB-first bits on rising sclk while sync is low,
// one-cycle word_valid per complete word, one-cycle frame_err for short or over-length frames.
module spi_rx #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned CNT_W = 5
) (
  input logic   sclk,
  input logic   spi_rst,
  spi_rx_if.slave link
);

  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] Full    = CNT_W'(WIDTH);

  typedef enum logic [1:0] {StIdle, StShift, StOver} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Only WIDTH-1 bits need holding; the WIDTH-th bit goes straight into data_out.
  logic [WIDTH-2:0] shift_q, shift_d;
  logic             overrun_q, overrun_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             err_q, err_d;
  logic [7:0]       fcount_q, fcount_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] shift_full;

  assign shift_full = {shift_q, link.din};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    overrun_d = overrun_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    fcount_d  = fcount_q;
    busy_d    = busy_q;

    if (!link.sync) begin
      busy_d = 1'b1;
      unique case (state_q)
        StIdle, StShift: begin
          shift_d = shift_full[WIDTH-2:0];
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LastBit) begin
            data_d   = shift_full;
            valid_d  = 1'b1;
            fcount_d = fcount_q + 8'd1;
            state_d  = StOver;
          end else begin
            state_d = StShift;
          end
        end
        StOver: begin
          overrun_d = 1'b1;
          cnt_d     = Full;
        end
        default: state_d = StIdle;
      endcase
    end else begin
      // Frame end: short frames and overruns both flag an error; the delivered word stands.
      if ((cnt_q != '0 && cnt_q < Full) || overrun_q) begin
        err_d = 1'b1;
      end
      cnt_d     = '0;
      overrun_d = 1'b0;
      busy_d    = 1'b0;
      shift_d   = '0;
      state_d   = StIdle;
    end
  end

  always_ff @(posedge sclk or negedge spi_rst) begin
    if (!spi_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      overrun_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      fcount_q  <= 8'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      overrun_q <= overrun_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      fcount_q  <= fcount_d;
      busy_q    <= busy_d;
    end
  end

  assign link.data_out    = data_q;
  assign link.word_valid  = valid_q;
  assign link.frame_err   = err_q;
  assign link.frame_count = fcount_q;
  assign link.busy        = busy_q;

endmodule

// File: tb/tb_spi_rx.sv
// Directed plus randomized bench for spi_rx against a frame-level reference model.
module tb_spi_rx;
  localparam int unsigned WIDTH = 24;
  localparam int unsigned CNT_W = 5;

  logic sclk;
  logic spi_rst;
  int   checks;
  int   errors;

  // Reference model state: last delivered word and good-frame count.
  logic [WIDTH-1:0] exp_data;
  int               exp_cnt;

  spi_rx_if #(.WIDTH(WIDTH)) link ();

  spi_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .sclk    (sclk),
    .spi_rst (spi_rst),
    .link    (link)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic valid, input logic err,
                             input logic bsy);
    chk({tag, ".word_valid"}, 32'(link.word_valid), 32'(valid));
    chk({tag, ".frame_err"}, 32'(link.frame_err), 32'(err));
    chk({tag, ".busy"}, 32'(link.busy), 32'(bsy));
    chk({tag, ".data_out"}, 32'(link.data_out), 32'(exp_data));
    chk({tag, ".frame_count"}, 32'(link.frame_count), exp_cnt);
  endtask

  // Shift n bits (MSB first from bits[n-1]); optionally close the frame with one idle cycle.
  task automatic send_frame(input int n, input logic [63:0] bits, input bit close);
    logic [63:0] w;
    for (int i = 0; i < n; i++) begin
      @(negedge sclk);
      link.sync = 1'b0;
      link.din  = bits[n-1-i];
      @(posedge sclk);
      #1;
      if (i == WIDTH - 1) begin
        w        = bits >> (n - WIDTH);
        exp_data = w[WIDTH-1:0];
        exp_cnt  = (exp_cnt + 1) % 256;
      end
      chk("bit", 32'(link.word_valid), 32'(i == WIDTH - 1));
      chk("bit.frame_err", 32'(link.frame_err), 32'd0);
      chk("bit.busy", 32'(link.busy), 32'd1);
      if (i == WIDTH - 1) begin
        chk("bit.data_out", 32'(link.data_out), 32'(exp_data));
        chk("bit.frame_count", 32'(link.frame_count), exp_cnt);
      end
    end
    if (close) begin
      idle(1, (n != WIDTH) && (n > 0));
    end
  endtask

  task automatic idle(input int cycles, input logic first_err);
    for (int i = 0; i < cycles; i++) begin
      @(negedge sclk);
      link.sync = 1'b1;
      link.din  = 1'bz;
      @(posedge sclk);
      #1;
      chk_outputs("idle", 1'b0, (i == 0) ? first_err : 1'b0, 1'b0);
    end
  endtask

  initial begin
    int          n;
    int          kind;
    logic [63:0] rbits;

    checks    = 0;
    errors    = 0;
    exp_data  = '0;
    exp_cnt   = 0;
    spi_rst   = 1'b0;
    link.sync = 1'b1;
    link.din  = 1'b0;
    #12;
    chk_outputs("reset", 1'b0, 1'b0, 1'b0);
    @(negedge sclk);
    spi_rst = 1'b1;
    idle(2, 1'b0);

    // Single good frame
    send_frame(WIDTH, 64'hA5C33C, 1'b1);
    chk("frame1.data", 32'(link.data_out), 32'hA5C33C);

    // Back-to-back frames with a single idle cycle
    send_frame(WIDTH, 64'hFFFFFF, 1'b1);
    send_frame(WIDTH, 64'h000001, 1'b1);
    chk("b2b.data", 32'(link.data_out), 32'h000001);
    chk("b2b.count", 32'(link.frame_count), 32'd3);

    // Short frame
    send_frame(10, 64'h2AB, 1'b1);
    chk("short.data", 32'(link.data_out), 32'h000001);

    // Over-length frame: 30 bits, top 24 are 0x123456
    send_frame(30, {34'd0, 24'h123456, 6'b101101}, 1'b1);
    chk("over.data", 32'(link.data_out), 32'h123456);
    chk("over.count", 32'(link.frame_count), 32'd4);

    // Reset mid-frame, then a clean frame
    send_frame(12, 64'hABC, 1'b0);
    @(negedge sclk);
    spi_rst   = 1'b0;
    link.sync = 1'b1;
    #1;
    exp_data = '0;
    exp_cnt  = 0;
    chk_outputs("midreset", 1'b0, 1'b0, 1'b0);
    @(negedge sclk);
    spi_rst = 1'b1;
    idle(2, 1'b0);
    send_frame(WIDTH, 64'h0F0F0F, 1'b1);
    chk("postreset.data", 32'(link.data_out), 32'h0F0F0F);
    chk("postreset.count", 32'(link.frame_count), 32'd1);

    // Random mix of lengths and idle gaps
    for (int f = 0; f < 40; f++) begin
      kind  = int'($urandom_range(2, 0));
      rbits = {$urandom(), $urandom()};
      if (kind == 0) n = WIDTH;
      else if (kind == 1) n = int'($urandom_range(WIDTH - 1, 1));
      else n = int'($urandom_range(40, WIDTH + 1));
      send_frame(n, rbits, 1'b1);
      idle(int'($urandom_range(2, 0)), 1'b0);
    end

    // 256 good frames from reset: count wraps to 0 on the 256th
    @(negedge sclk);
    spi_rst = 1'b0;
    #1;
    exp_data = '0;
    exp_cnt  = 0;
    @(negedge sclk);
    spi_rst = 1'b1;
    for (int f = 0; f < 256; f++) begin
      rbits = {32'd0, $urandom()};
      send_frame(WIDTH, rbits, 1'b1);
    end
    chk("wrap.count", 32'(link.frame_count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
